// File: rtl/mips_defs_pkg.sv
// Shared MIPS opcode/funct encodings and architectural register numbers.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] REG_RA     = 5'd31;
  localparam logic [4:0] REG_ZERO   = 5'd0;

  // Immediate ALU ops occupy the opcode block 0x08-0x0f.
  function automatic logic is_cal_i(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/hctrl.sv
// Instruction class decoder shared by pipeline stages.
module hctrl
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output logic        cal_r,
  output logic        cal_i,
  output logic        load,
  output logic        store,
  output logic        jal,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  // jr/jalr live in the SPECIAL space but are not register-writing ALU ops here.
  assign cal_r = (op == OP_SPECIAL) && (funct != FN_JR) && (funct != FN_JALR);
  assign cal_i = is_cal_i(op);
  assign load  = (op == OP_LW);
  assign store = (op == OP_SW);
  assign jal   = (op == OP_JAL);

endmodule

// File: rtl/mw_result_pipe.sv
// MEM->WB register, write-back source select, store-data forwarding, counters.
module mw_result_pipe
  import mips_defs::*;
#(
  parameter int RET_W = 32,
  parameter int FWD_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [31:0]      instrM,
  input  logic [31:0]      pc8M,
  input  logic [31:0]      alu_outM,
  input  logic [31:0]      mem_rdataM,
  input  logic [31:0]      rt_dataM,
  output logic [31:0]      store_dataM,
  output logic             fwd_hitM,
  output logic [31:0]      instrW,
  output logic [4:0]       wb_regW,
  output logic [31:0]      wb_dataW,
  output logic             wb_weW,
  output logic [RET_W-1:0] ret_cnt,
  output logic [FWD_W-1:0] fwd_cnt
);

  logic [31:0] pc8W, aluW, memW;

  // M-side decode: only store and rt are needed
  logic       storeM;
  logic [4:0] rtM;
  logic       m_cal_r, m_cal_i, m_load, m_jal;
  logic [4:0] m_rs, m_rd;

  // W-side decode
  logic       cal_rW, cal_iW, loadW, storeW, jalW;
  logic [4:0] rsW, rtW, rdW;

  logic unused_sig;
  assign unused_sig = ^{m_cal_r, m_cal_i, m_load, m_jal, m_rs, m_rd, storeW, rsW};

  hctrl u_hctrl_m (
    .instr (instrM), .cal_r(m_cal_r), .cal_i(m_cal_i), .load(m_load),
    .store (storeM), .jal  (m_jal),   .rs   (m_rs),    .rt  (rtM),   .rd(m_rd)
  );

  hctrl u_hctrl_w (
    .instr (instrW), .cal_r(cal_rW), .cal_i(cal_iW), .load(loadW),
    .store (storeW), .jal  (jalW),   .rs   (rsW),    .rt  (rtW),   .rd(rdW)
  );

  // W register bank: reset > flush (bubble) > en (capture) > hold
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instrW <= '0;
      pc8W   <= '0;
      aluW   <= '0;
      memW   <= '0;
    end else if (en) begin
      instrW <= instrM;
      pc8W   <= pc8M;
      aluW   <= alu_outM;
      memW   <= mem_rdataM;
    end
  end

  // Event counters, wrapping; they only count real M->W advances
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_cnt <= '0;
      fwd_cnt <= '0;
    end else if (en && !flush) begin
      if (instrM != 32'd0) ret_cnt <= ret_cnt + 1'b1;
      if (fwd_hitM)        fwd_cnt <= fwd_cnt + 1'b1;
    end
  end

  // Destination register and write-back data from the W instruction class
  always_comb begin
    wb_regW  = REG_ZERO;
    wb_dataW = 32'd0;
    if (cal_rW) begin
      wb_regW  = rdW;
      wb_dataW = aluW;
    end else if (cal_iW) begin
      wb_regW  = rtW;
      wb_dataW = aluW;
    end else if (loadW) begin
      wb_regW  = rtW;
      wb_dataW = memW;
    end else if (jalW) begin
      wb_regW  = REG_RA;
      wb_dataW = pc8W;
    end
  end

  // $0 never writes, so it also never forwards
  assign wb_weW      = (wb_regW != REG_ZERO);
  assign fwd_hitM    = storeM && wb_weW && (wb_regW == rtM);
  assign store_dataM = fwd_hitM ? wb_dataW : rt_dataM;

endmodule

// File: tb/tb_mw_result_pipe.sv
// Directed scoreboard bench for mw_result_pipe.
module tb_mw_result_pipe;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic [31:0] instrM, pc8M, alu_outM, mem_rdataM, rt_dataM;
  logic [31:0] store_dataM, instrW, wb_dataW;
  logic        fwd_hitM, wb_weW;
  logic [4:0]  wb_regW;
  logic [31:0] ret_cnt;
  logic [15:0] fwd_cnt;

  mw_result_pipe #(.RET_W(32), .FWD_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .instrM(instrM), .pc8M(pc8M), .alu_outM(alu_outM), .mem_rdataM(mem_rdataM),
    .rt_dataM(rt_dataM), .store_dataM(store_dataM), .fwd_hitM(fwd_hitM),
    .instrW(instrW), .wb_regW(wb_regW), .wb_dataW(wb_dataW), .wb_weW(wb_weW),
    .ret_cnt(ret_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  localparam int S_INSTRW = 0, S_REG = 1, S_DATA = 2, S_WE = 3,
                 S_HIT = 4, S_SDATA = 5, S_RET = 6, S_FWD = 7;

  localparam logic [31:0] ADDU = 32'h00221821;
  localparam logic [31:0] LW5  = 32'h8C050004;

  typedef struct {
    int          cyc;
    string       nm;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic r, input logic e, input logic f,
                       input logic [31:0] ins, input logic [31:0] pc8,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] rt);
    @(posedge clk); #1;
    reset = r; en = e; flush = f; instrM = ins;
    pc8M = pc8; alu_outM = alu; mem_rdataM = mem; rt_dataM = rt;
  endtask

  task automatic expect_v(input string nm, input int sel, input logic [31:0] v);
    exp_t x;
    x.cyc = cyc; x.nm = nm; x.sel = sel; x.val = v;
    q.push_back(x);
  endtask

  // Monitor: compare every expectation registered for the current cycle
  always @(negedge clk) begin : mon
    exp_t        x;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      case (x.sel)
        S_INSTRW: act = instrW;
        S_REG:    act = {27'd0, wb_regW};
        S_DATA:   act = wb_dataW;
        S_WE:     act = {31'd0, wb_weW};
        S_HIT:    act = {31'd0, fwd_hitM};
        S_SDATA:  act = store_dataM;
        S_RET:    act = ret_cnt;
        default:  act = {16'd0, fwd_cnt};
      endcase
      checks++;
      if (x.cyc != cyc || act !== x.val) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h expected=%h", x.nm, x.cyc, act, x.val);
      end
    end
  end

  initial begin : wdog
    #100000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1; en = 1; flush = 0; instrM = ADDU;
    pc8M = 0; alu_outM = 0; mem_rdataM = 0; rt_dataM = 0;

    // reset held with en and a valid instruction
    drive(1, 1, 0, ADDU, 0, 0, 0, 0);
    expect_v("rst_we", S_WE, 0);  expect_v("rst_instrW", S_INSTRW, 0);
    expect_v("rst_ret", S_RET, 0); expect_v("rst_fwd", S_FWD, 0);
    drive(0, 1, 0, ADDU, 0, 32'h1234, 0, 0);
    expect_v("rst2_we", S_WE, 0); expect_v("rst2_ret", S_RET, 0);

    // addu $3 then sw $3: forward ALU result
    drive(0, 1, 0, 32'hAC030000, 0, 0, 0, 32'hDEAD);
    expect_v("addu_reg", S_REG, 3); expect_v("addu_data", S_DATA, 32'h1234);
    expect_v("addu_hit", S_HIT, 1); expect_v("addu_sdata", S_SDATA, 32'h1234);
    expect_v("addu_ret", S_RET, 1); expect_v("addu_fwd", S_FWD, 0);

    // lw $5 then sw $5: forward load data
    drive(0, 1, 0, LW5, 0, 4, 32'hCAFE, 32'h1111);
    expect_v("sw_we", S_WE, 0); expect_v("sw_ret", S_RET, 2);
    expect_v("sw_fwd", S_FWD, 1); expect_v("lwM_hit", S_HIT, 0);
    expect_v("lwM_sdata", S_SDATA, 32'h1111);
    drive(0, 1, 0, 32'hAC050008, 0, 8, 0, 32'hBEEF);
    expect_v("lw_reg", S_REG, 5); expect_v("lw_hit", S_HIT, 1);
    expect_v("lw_sdata", S_SDATA, 32'hCAFE);

    // lw $5 then sw $6: no forward
    drive(0, 1, 0, LW5, 0, 4, 32'hCAFE, 0);
    expect_v("fwd2", S_FWD, 2);
    drive(0, 1, 0, 32'hAC060008, 0, 8, 0, 32'h6666);
    expect_v("sw6_hit", S_HIT, 0); expect_v("sw6_sdata", S_SDATA, 32'h6666);

    // jal then sw $31: forward link value
    drive(0, 1, 0, 32'h0C000010, 32'h3008, 0, 0, 0);
    drive(0, 1, 0, 32'hAC1F0000, 0, 0, 0, 32'h7777);
    expect_v("jal_reg", S_REG, 31); expect_v("jal_data", S_DATA, 32'h3008);
    expect_v("jal_hit", S_HIT, 1); expect_v("jal_sdata", S_SDATA, 32'h3008);
    expect_v("jal_ret", S_RET, 7);

    // ori $0 then sw $0: $0 never writes or forwards
    drive(0, 1, 0, 32'h34000005, 0, 5, 0, 0);
    expect_v("jal_fwd", S_FWD, 3);
    drive(0, 1, 0, 32'hAC000000, 0, 0, 0, 32'h8888);
    expect_v("ori0_we", S_WE, 0); expect_v("ori0_hit", S_HIT, 0);
    expect_v("ori0_sdata", S_SDATA, 32'h8888);

    // addu then 3 cycles of hold
    drive(0, 1, 0, ADDU, 0, 32'hABCD, 0, 0);
    expect_v("pre_hold_ret", S_RET, 10); expect_v("pre_hold_fwd", S_FWD, 3);
    drive(0, 0, 0, LW5, 0, 1, 2, 3);
    expect_v("hold0_data", S_DATA, 32'hABCD); expect_v("hold0_ret", S_RET, 11);
    drive(0, 0, 0, LW5, 0, 1, 2, 3);
    expect_v("hold1_instrW", S_INSTRW, ADDU); expect_v("hold1_ret", S_RET, 11);
    drive(0, 0, 0, LW5, 0, 1, 2, 3);
    expect_v("hold2_we", S_WE, 1); expect_v("hold2_data", S_DATA, 32'hABCD);
    expect_v("hold2_ret", S_RET, 11);

    // flush wins over en
    drive(0, 1, 1, LW5, 0, 1, 2, 3);
    expect_v("hold3_instrW", S_INSTRW, ADDU); expect_v("hold3_ret", S_RET, 11);
    drive(0, 1, 0, 32'd0, 0, 0, 0, 0);
    expect_v("flush_instrW", S_INSTRW, 0); expect_v("flush_we", S_WE, 0);
    expect_v("flush_ret", S_RET, 11); expect_v("flush_fwd", S_FWD, 3);

    // counter wrap: preload all-ones, then capture a real instruction
    drive(0, 1, 0, ADDU, 0, 0, 0, 0);
    expect_v("nop_noinc", S_RET, 11);
    @(negedge clk); #1;
    force dut.ret_cnt = 32'hFFFFFFFF;
    #1;
    release dut.ret_cnt;
    drive(0, 1, 0, 32'd0, 0, 0, 0, 0);
    expect_v("wrap_ret", S_RET, 0);
    drive(0, 1, 0, 32'd0, 0, 0, 0, 0);
    expect_v("wrap_nop_ret", S_RET, 0);

    // reset mid-stream discards W even with en and a valid instruction
    drive(0, 1, 0, ADDU, 0, 32'h55, 0, 0);
    drive(1, 1, 0, ADDU, 0, 32'h55, 0, 0);
    expect_v("pre_mid_we", S_WE, 1); expect_v("pre_mid_ret", S_RET, 1);
    drive(0, 1, 0, ADDU, 0, 32'h66, 0, 0);
    expect_v("mid_we", S_WE, 0); expect_v("mid_instrW", S_INSTRW, 0);
    expect_v("mid_ret", S_RET, 0); expect_v("mid_fwd", S_FWD, 0);
    drive(0, 0, 0, 32'd0, 0, 0, 0, 0);
    expect_v("post_mid_we", S_WE, 1); expect_v("post_mid_data", S_DATA, 32'h66);
    expect_v("post_mid_ret", S_RET, 1);

    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
